// File: rtl/btn_event_queue.sv
// rtl/btn_event_queue.sv - debounced push-button press detector feeding a show-ahead event FIFO
// Each button is synchronised, debounced and edge-detected; presses become 3-bit codes popped by the CPU.
module btn_event_queue #(
   parameter int NBTN       = 5,
   parameter int DEB_CYCLES = 16,
   parameter int DEPTH      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBTN-1:0] btn,
   input  logic            rd_en,
   input  logic            ovf_clr,
   output logic            ev_valid,
   output logic [2:0]      ev_code,
   output logic [2:0]      ev_count,
   output logic            ev_ovf
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [NBTN-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [NBTN-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
   logic [DW-1:0]   cnt_q [NBTN];
   logic [DW-1:0]   cnt_d [NBTN];
   logic [2:0]      mem_q [DEPTH];
   logic [2:0]      mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;

   logic [NBTN-1:0] rise;
   logic [2:0]      push_code;
   logic            do_pop, do_push, full, clash, ovf_set;

   always_comb begin
      s1_d       = btn;
      s2_d       = s1_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
               deb_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DW'(1);
            end
         end
      end
   end

   // Presses come from the registered debounced level, adding the one enqueue cycle of latency.
   always_comb begin
      rise      = deb_q & ~deb_prev_q;
      push_code = 3'd0;
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (rise[i]) push_code = 3'(i + 1);
      end
      clash   = |(rise & (rise - NBTN'(1)));
      full    = (count_q == CW'(DEPTH));
      do_pop  = rd_en && (count_q != '0);
      do_push = (|rise) && (!full || do_pop);
      ovf_set = clash || ((|rise) && full && !do_pop);

      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = push_code;
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);

      ovf_d = ovf_clr ? 1'b0 : (ovf_q | ovf_set);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
         for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
         for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ev_valid = (count_q != '0);
   assign ev_code  = ev_valid ? mem_q[rd_ptr_q] : 3'd0;
   assign ev_count = 3'(count_q);
   assign ev_ovf   = ovf_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// tb/tb_btn_event_queue.sv - randomized and directed bench for btn_event_queue against a queue-based reference
module tb_btn_event_queue;

   localparam int NBTN  = 5;
   localparam int DEB   = 16;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NBTN-1:0] btn = '0;
   logic            rd_en = 1'b0;
   logic            ovf_clr = 1'b0;
   logic            ev_valid;
   logic [2:0]      ev_code;
   logic [2:0]      ev_count;
   logic            ev_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   btn_event_queue #(.NBTN(NBTN), .DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .btn(btn), .rd_en(rd_en), .ovf_clr(ovf_clr),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_count(ev_count), .ev_ovf(ev_ovf)
   );

   always #5 clk = ~clk;

   // Reference: btn delay line, per-button disagreement run length, event queue.
   bit [NBTN-1:0] m_hist1, m_hist2, m_deb, m_deb_old;
   int            m_run [NBTN];
   int            m_q [$];
   bit            m_ovf;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist1 = '0; m_hist2 = '0; m_deb = '0; m_deb_old = '0;
      for (int i = 0; i < NBTN; i++) m_run[i] = 0;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      bit [NBTN-1:0] r;
      bit lost;
      r = m_deb & ~m_deb_old;
      lost = 1'b0;
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (r != 0) begin
         int code;
         code = 0;
         for (int i = NBTN - 1; i >= 0; i--) if (r[i]) code = i + 1;
         if ($countones(r) > 1) lost = 1'b1;
         if (m_q.size() < DEPTH) m_q.push_back(code);
         else lost = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      else if (lost) m_ovf = 1'b1;
      m_deb_old = m_deb;
      for (int i = 0; i < NBTN; i++) begin
         if (m_hist2[i] == m_deb[i]) m_run[i] = 0;
         else begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_deb[i] = m_hist2[i];
               m_run[i] = 0;
            end
         end
      end
      m_hist2 = m_hist1;
      m_hist1 = btn;
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_valid"}, ev_valid, (m_q.size() > 0) ? 1 : 0);
      check({tag, "_code"},  ev_code,  (m_q.size() > 0) ? m_q[0] : 0);
      check({tag, "_count"}, ev_count, m_q.size());
      check({tag, "_ovf"},   ev_ovf,   m_ovf);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_model("cyc");
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      btn = '0; rd_en = 1'b0; ovf_clr = 1'b0;
      #1;
      model_reset();
      check("rst_valid", ev_valid, 0);
      check("rst_code",  ev_code,  0);
      check("rst_count", ev_count, 0);
      check("rst_ovf",   ev_ovf,   0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press(input int idx, input int hold);
      btn[idx] = 1'b1;
      repeat (hold) cycle();
      btn[idx] = 1'b0;
      repeat (DEB + 4) cycle();
   endtask

   initial begin
      model_reset();
      #12;
      do_reset();

      // 1: held press appears exactly DEB+2 edges after first sampling edge
      btn[2] = 1'b1;
      repeat (DEB + 2) cycle();
      check("t1_valid_early", ev_valid, 0);
      cycle();
      check("t1_valid", ev_valid, 1);
      check("t1_code",  ev_code,  3);
      check("t1_count", ev_count, 1);
      repeat (11) cycle();
      btn[2] = 1'b0;
      repeat (DEB + 4) cycle();
      do_reset();

      // 2: short glitch produces nothing
      btn[0] = 1'b1;
      repeat (10) cycle();
      btn[0] = 1'b0;
      repeat (40) cycle();
      check("t2_valid", ev_valid, 0);
      check("t2_ovf",   ev_ovf,   0);

      // 3: five presses, no reads
      for (int i = 0; i < NBTN; i++) press(i, DEB + 4);
      check("t3_count", ev_count, 4);
      check("t3_ovf",   ev_ovf,   1);
      check("t3_head",  ev_code,  1);
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      check("t3_clr", ev_ovf, 0);

      // 5: full FIFO, pop on the very cycle the new press enqueues
      btn[4] = 1'b1;
      repeat (DEB + 6) begin
         rd_en = ((m_deb & ~m_deb_old) != 0);
         cycle();
      end
      rd_en = 1'b0;
      btn[4] = 1'b0;
      repeat (DEB + 4) cycle();
      check("t5_count", ev_count, 4);
      check("t5_head",  ev_code,  2);
      check("t5_ovf",   ev_ovf,   0);
      rd_en = 1'b1;
      repeat (5) cycle();
      rd_en = 1'b0;
      check("t5_empty_count", ev_count, 0);
      check("t5_empty_code",  ev_code,  0);

      // 4: simultaneous rise of btn[1] and btn[3]
      btn[1] = 1'b1; btn[3] = 1'b1;
      repeat (DEB + 4) cycle();
      btn = '0;
      repeat (DEB + 4) cycle();
      check("t4_count", ev_count, 1);
      check("t4_code",  ev_code,  2);
      check("t4_ovf",   ev_ovf,   1);

      // 6: reset mid-debounce with two queued
      press(2, DEB + 4);
      check("t6_pre_count", ev_count, 2);
      btn[0] = 1'b1;
      repeat (8) cycle();
      do_reset();
      repeat (DEB + 4) cycle();

      // Random phase
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NBTN; i++) if ($urandom_range(0, 24) == 0) btn[i] = ~btn[i];
         rd_en   = ($urandom_range(0, 3) == 0);
         ovf_clr = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
